// File: rtl/mcd_pkg.sv
// Shared types for the sub-side memory port arbiter: FSM states, owner codes
// and the 19-bit sub-bus byte address.
package mcd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUB      = 2'd1,
    DMA_WR   = 2'd2,
    DMA_DONE = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_SUB  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  typedef logic [18:0] sub_addr_t;

endpackage

// File: rtl/cdc_arb_wait_ctr.sv
// Saturating count of ticks a DMA word has been deferred; raises force_grant
// once the deferral reaches MAX_WAIT so the next arbitration goes to DMA.
module cdc_arb_wait_ctr
#(
  parameter int MAX_WAIT = 6
)
(
  input  logic clk_asic,
  input  logic rst,
  input  logic sub_sync,
  input  logic dma_req,
  input  logic dma_busy,
  input  logic dma_done,
  output logic force_grant
);

  localparam int            WW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait_ctr_r;

  // Counts only while the word is pending and not yet on the port
  always_ff @(negedge clk_asic) begin
    if (rst) begin
      wait_ctr_r <= {WW{1'b0}};
    end else if (sub_sync) begin
      if (dma_done || !dma_req) begin
        wait_ctr_r <= {WW{1'b0}};
      end else if (!dma_busy && (wait_ctr_r < WAIT_MAX)) begin
        wait_ctr_r <= wait_ctr_r + WW'(1);
      end else begin
        wait_ctr_r <= wait_ctr_r;
      end
    end
  end

  assign force_grant = (wait_ctr_r >= WAIT_MAX);

endmodule

// File: rtl/cdc_dma_arb.sv
// Sub-CPU / CDC DMA arbiter for the shared 16-bit sub-side memory port.
// Optional statistics outputs (dma_words, starve_hits) under CDC_ARB_STAT_EN.
module cdc_dma_arb
  import mcd_pkg::*;
#(
  parameter int MAX_WAIT = 6,
  parameter int WR_HOLD  = 2
)
(
  input  logic        clk_asic,
  input  logic        rst,
  input  logic        sub_sync,
  input  logic        sub_req,
  input  logic        sub_we,
  input  sub_addr_t   sub_addr,
  input  logic [15:0] sub_dat,
  output logic        sub_wait,
  input  logic        dma_req,
  input  sub_addr_t   dma_addr,
  input  logic [15:0] dma_dat,
  output logic        dma_ack,
  input  logic        port_blocked,
  output sub_addr_t   mem_addr,
  output logic [15:0] mem_dat,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [1:0]  owner
`ifdef CDC_ARB_STAT_EN
  ,
  output logic [15:0] dma_words,
  output logic [7:0]  starve_hits
`endif
);

  localparam int            HW       = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_TOP = HW'(WR_HOLD - 1);

  arb_state_e    state_r, state_s;
  logic [HW-1:0] hold_r, hold_s;
  sub_addr_t     addr_r, addr_s;
  logic [15:0]   dat_r, dat_s;
  logic          oe_r, oe_s;
  logic          we_r, we_s;
  logic          ack_r, ack_s;
  logic [1:0]    owner_r, owner_s;
  logic          force_grant_s;
  logic          dma_win_s;

  cdc_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait_ctr (
    .clk_asic    (clk_asic),
    .rst         (rst),
    .sub_sync    (sub_sync),
    .dma_req     (dma_req),
    .dma_busy    (state_r == DMA_WR),
    .dma_done    (state_r == DMA_DONE),
    .force_grant (force_grant_s)
  );

  assign dma_win_s = dma_req && !port_blocked && (!sub_req || force_grant_s);

  // Next-state and next-output decode for one sub_sync tick
  always_comb begin
    state_s = state_r;
    hold_s  = hold_r;
    addr_s  = addr_r;
    dat_s   = dat_r;
    oe_s    = oe_r;
    we_s    = we_r;
    ack_s   = 1'b0;
    owner_s = owner_r;
    case (state_r)
      IDLE: begin
        if (dma_win_s) begin
          state_s = DMA_WR;
          hold_s  = HOLD_TOP;
          addr_s  = dma_addr;
          dat_s   = dma_dat;
          oe_s    = 1'b0;
          we_s    = 1'b1;
          owner_s = OWN_DMA;
        end else if (sub_req) begin
          state_s = SUB;
          addr_s  = sub_addr;
          dat_s   = sub_dat;
          oe_s    = !sub_we;
          we_s    = sub_we;
          owner_s = OWN_SUB;
        end else begin
          oe_s    = 1'b0;
          we_s    = 1'b0;
          owner_s = OWN_IDLE;
        end
      end
      SUB: begin
        // Keep the last sub address/data latched for when the port goes idle
        addr_s = sub_addr;
        dat_s  = sub_dat;
        if (sub_req) begin
          oe_s = !sub_we;
          we_s = sub_we;
        end else begin
          state_s = IDLE;
          oe_s    = 1'b0;
          we_s    = 1'b0;
          owner_s = OWN_IDLE;
        end
      end
      DMA_WR: begin
        if (port_blocked) begin
          state_s = IDLE;
          we_s    = 1'b0;
          owner_s = OWN_IDLE;
        end else if (hold_r == {HW{1'b0}}) begin
          state_s = DMA_DONE;
          we_s    = 1'b0;
          ack_s   = 1'b1;
        end else begin
          hold_s = hold_r - HW'(1);
        end
      end
      DMA_DONE: begin
        state_s = IDLE;
        owner_s = OWN_IDLE;
      end
      default: begin
        state_s = IDLE;
        oe_s    = 1'b0;
        we_s    = 1'b0;
        owner_s = OWN_IDLE;
      end
    endcase
  end

  // State and registered port outputs, advanced only on sub_sync ticks
  always_ff @(negedge clk_asic) begin
    if (rst) begin
      state_r <= IDLE;
      hold_r  <= {HW{1'b0}};
      addr_r  <= 19'h0_0000;
      dat_r   <= 16'h0000;
      oe_r    <= 1'b0;
      we_r    <= 1'b0;
      ack_r   <= 1'b0;
      owner_r <= OWN_IDLE;
    end else if (sub_sync) begin
      state_r <= state_s;
      hold_r  <= hold_s;
      addr_r  <= addr_s;
      dat_r   <= dat_s;
      oe_r    <= oe_s;
      we_r    <= we_s;
      ack_r   <= ack_s;
      owner_r <= owner_s;
    end
  end

  // A live sub cycle drives address/data straight through
  assign mem_addr = (state_r == SUB) ? sub_addr : addr_r;
  assign mem_dat  = (state_r == SUB) ? sub_dat  : dat_r;
  assign mem_oe   = oe_r;
  assign mem_we   = we_r;
  assign dma_ack  = ack_r;
  assign owner    = owner_r;
  assign sub_wait = (state_r == DMA_WR) && sub_req;

`ifdef CDC_ARB_STAT_EN
  logic [15:0] dma_words_r;
  logic [7:0]  starve_hits_r;
  logic        starve_grant_s;

  assign starve_grant_s = (state_r == IDLE) && dma_win_s && sub_req;

  // Wrapping usage counters
  always_ff @(negedge clk_asic) begin
    if (rst) begin
      dma_words_r   <= 16'h0000;
      starve_hits_r <= 8'h00;
    end else if (sub_sync) begin
      if (ack_s) begin
        dma_words_r <= dma_words_r + 16'h0001;
      end
      if (starve_grant_s) begin
        starve_hits_r <= starve_hits_r + 8'h01;
      end
    end
  end

  assign dma_words   = dma_words_r;
  assign starve_hits = starve_hits_r;
`endif

endmodule

// File: tb/tb_cdc_dma_arb.sv
// Self-checking bench for cdc_dma_arb: directed vector table, hand sequences
// for the multi-tick corner cases, and random traffic against a tick model.
module tb_cdc_dma_arb;

  localparam int MAXW = 6;
  localparam int HOLD = 2;

  logic        clk_asic = 1'b0;
  logic        rst = 1'b1;
  logic        sub_sync = 1'b0;
  logic        sub_req = 1'b0;
  logic        sub_we = 1'b0;
  logic [18:0] sub_addr = 19'h0;
  logic [15:0] sub_dat = 16'h0;
  logic        sub_wait;
  logic        dma_req = 1'b0;
  logic [18:0] dma_addr = 19'h0;
  logic [15:0] dma_dat = 16'h0;
  logic        dma_ack;
  logic        port_blocked = 1'b0;
  logic [18:0] mem_addr;
  logic [15:0] mem_dat;
  logic        mem_oe;
  logic        mem_we;
  logic [1:0]  owner;
`ifdef CDC_ARB_STAT_EN
  logic [15:0] dma_words;
  logic [7:0]  starve_hits;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_asic = ~clk_asic;

  cdc_dma_arb #(.MAX_WAIT(MAXW), .WR_HOLD(HOLD)) dut (
    .clk_asic     (clk_asic),
    .rst          (rst),
    .sub_sync     (sub_sync),
    .sub_req      (sub_req),
    .sub_we       (sub_we),
    .sub_addr     (sub_addr),
    .sub_dat      (sub_dat),
    .sub_wait     (sub_wait),
    .dma_req      (dma_req),
    .dma_addr     (dma_addr),
    .dma_dat      (dma_dat),
    .dma_ack      (dma_ack),
    .port_blocked (port_blocked),
    .mem_addr     (mem_addr),
    .mem_dat      (mem_dat),
    .mem_oe       (mem_oe),
    .mem_we       (mem_we),
    .owner        (owner)
`ifdef CDC_ARB_STAT_EN
    ,
    .dma_words    (dma_words),
    .starve_hits  (starve_hits)
`endif
  );

  // Reference model: who holds the port, how many write ticks remain,
  // whether this is the ack tick, and how long the pending word has waited.
  int          m_own;
  int          m_wr_left;
  bit          m_done;
  int          m_waited;
  logic        m_oe, m_we, m_ack;
  logic [18:0] m_addr;
  logic [15:0] m_dat;

  task automatic model_reset();
    m_own = 0; m_wr_left = 0; m_done = 1'b0; m_waited = 0;
    m_oe = 1'b0; m_we = 1'b0; m_ack = 1'b0; m_addr = 19'h0; m_dat = 16'h0;
  endtask

  task automatic model_step();
    int  nw;
    bit  writing;
    writing = (m_own == 2) && !m_done;
    if (m_done || !dma_req) nw = 0;
    else if (writing)       nw = m_waited;
    else                    nw = (m_waited < MAXW) ? m_waited + 1 : MAXW;
    if (m_done) begin
      m_done = 1'b0; m_ack = 1'b0; m_own = 0;
    end else if (writing) begin
      if (port_blocked) begin
        m_we = 1'b0; m_own = 0;
      end else begin
        m_wr_left--;
        if (m_wr_left == 0) begin
          m_we = 1'b0; m_done = 1'b1; m_ack = 1'b1;
        end
      end
    end else if (m_own == 1) begin
      m_addr = sub_addr; m_dat = sub_dat;
      if (sub_req) begin
        m_oe = !sub_we; m_we = sub_we;
      end else begin
        m_own = 0; m_oe = 1'b0; m_we = 1'b0;
      end
    end else if (dma_req && !port_blocked && (!sub_req || m_waited >= MAXW)) begin
      m_own = 2; m_wr_left = HOLD; m_we = 1'b1; m_oe = 1'b0;
      m_addr = dma_addr; m_dat = dma_dat;
    end else if (sub_req) begin
      m_own = 1; m_oe = !sub_we; m_we = sub_we; m_addr = sub_addr; m_dat = sub_dat;
    end
    m_waited = nw;
  endtask

  function automatic logic [40:0] dut_vec();
    return {owner, mem_oe, mem_we, dma_ack, sub_wait, mem_addr, mem_dat};
  endfunction

  function automatic logic [40:0] model_vec();
    logic [1:0] own2;
    logic       wt;
    own2 = 2'(m_own);
    wt   = (m_own == 2) && !m_done && sub_req;
    return {own2, m_oe, m_we, m_ack, wt,
            (m_own == 1) ? sub_addr : m_addr,
            (m_own == 1) ? sub_dat  : m_dat};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, let the falling edge happen, then compare to model.
  task automatic tick(input logic ss, input logic sr, input logic sw,
                      input logic dr, input logic pb, input logic r);
    sub_sync = ss; sub_req = sr; sub_we = sw; dma_req = dr; port_blocked = pb; rst = r;
    @(negedge clk_asic);
    if (r) model_reset();
    else if (ss) model_step();
    #2;
    chk("model", 64'(dut_vec()), 64'(model_vec()));
  endtask

  typedef struct {
    int          gap;
    logic        sr, sw, dr, pb;
    logic [1:0]  own;
    logic        oe, we, ack, wt;
    logic [18:0] addr;
    logic [15:0] dat;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int grant_at;
    int acks;

    // DMA alone (sub_sync every 4 clocks), then sub priority and a sub write
    tbl[0]  = '{3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 19'h01000, 16'hA55A};
    tbl[1]  = '{3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 19'h01000, 16'hA55A};
    tbl[2]  = '{3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 19'h01000, 16'hA55A};
    tbl[3]  = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 19'h01000, 16'hA55A};
    tbl[4]  = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h12345, 16'h5A5A};
    tbl[5]  = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h12345, 16'h5A5A};
    tbl[6]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 19'h12345, 16'h5A5A};
    tbl[7]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 19'h01000, 16'hA55A};
    tbl[8]  = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 19'h01000, 16'hA55A};
    tbl[9]  = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 19'h01000, 16'hA55A};
    tbl[10] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 19'h01000, 16'hA55A};
    tbl[11] = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 19'h12345, 16'h5A5A};
    tbl[12] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 19'h12345, 16'h5A5A};

    model_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset", 64'(dut_vec()), 64'd0);

    dma_addr = 19'h01000; dma_dat = 16'hA55A;
    sub_addr = 19'h12345; sub_dat = 16'h5A5A;
    for (int i = 0; i < 13; i++) begin
      for (int g = 0; g < tbl[i].gap; g++)
        tick(1'b0, tbl[i].sr, tbl[i].sw, tbl[i].dr, tbl[i].pb, 1'b0);
      tick(1'b1, tbl[i].sr, tbl[i].sw, tbl[i].dr, tbl[i].pb, 1'b0);
      chk($sformatf("vec%0d", i), 64'(dut_vec()),
          64'({tbl[i].own, tbl[i].oe, tbl[i].we, tbl[i].ack, tbl[i].wt, tbl[i].addr, tbl[i].dat}));
    end

    // Starvation: back-to-back sub cycles with 1-tick gaps, DMA held
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    grant_at = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, (i % 3) != 2, 1'b0, 1'b1, 1'b0, 1'b0);
      if (owner == 2'd2) begin
        grant_at = i;
        chk("starve_sub_wait", 64'(sub_wait), 64'd1);
        break;
      end
    end
    chk("starve_grant_by_7th_tick", 64'(grant_at >= 0 && grant_at <= MAXW), 64'd1);

    // Blocked abort, then retry of the same word with a single ack
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    dma_addr = 19'h2BEEF; dma_dat = 16'hC3C3;
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("blk_we_on", 64'(mem_we), 64'd1);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("blk_abort", 64'({owner, mem_we, dma_ack}), 64'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("blk_idle", 64'({owner, mem_we}), 64'd0);
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b0, 1'b0, acks == 0, 1'b0, 1'b0);
      if (mem_we) chk("blk_retry_addr", 64'({mem_addr, mem_dat}), 64'({19'h2BEEF, 16'hC3C3}));
      if (dma_ack) acks++;
    end
    chk("blk_one_ack", 64'(acks), 64'd1);

    // Reset mid-write
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_we_on", 64'(mem_we), 64'd1);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_write", 64'({owner, mem_we, dma_ack}), 64'd0);
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (dma_ack) acks++;
    end
    chk("rst_no_ack", 64'(acks), 64'd0);

    // sub_sync gating mid-write: nothing moves for 10 clocks
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("gate_frozen", 64'({owner, mem_we, dma_ack}), 64'({2'd2, 1'b1, 1'b0}));
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("gate_hold2", 64'({mem_we, dma_ack}), 64'({1'b1, 1'b0}));
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("gate_done", 64'({mem_we, dma_ack}), 64'({1'b0, 1'b1}));
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sub_addr = 19'($urandom); sub_dat = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        dma_addr = 19'($urandom); dma_dat = 16'($urandom);
      end
      tick($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_dma_arb.md
Name: cdc_dma_arb

Overview:
- Arbitrates one shared 16-bit sub-side memory port (PRG-RAM / word RAM / PCM window) between sub-CPU bus cycles and CDC DMA word writes.
- Sits between the CDC DMA engine, the sub-CPU bus decode and the memory mux.
- Replaces the "wait for sub cycle end" gating with explicit request/grant slots.
- Sub CPU has priority; DMA gets a guaranteed slot after a bounded wait.

Parameters:
- MAX_WAIT, 6: number of sub_sync ticks a pending DMA request may be deferred before it wins the next arbitration.
- WR_HOLD, 2: sub_sync ticks mem_we is held for a DMA write (minimum 1).

Ports:
- clk_asic  in  1  system clock; all logic on negedge clk_asic.
- rst  in  1  synchronous, active-high reset.
- sub_sync  in  1  clock enable; all state advances only when high.
- sub_req  in  1  sub-CPU cycle to the shared memory (decoded AS & CE).
- sub_we  in  1  sub-CPU cycle is a write.
- sub_addr  in  19  sub-CPU byte address.
- sub_dat  in  16  sub-CPU write data.
- sub_wait  out  1  stall sub CPU (DTACK withheld) while DMA owns the port.
- dma_req  in  1  DMA word pending (level; held until dma_ack).
- dma_addr  in  19  DMA byte address.
- dma_dat  in  16  DMA write data.
- dma_ack  out  1  one-tick pulse when the DMA write completes.
- port_blocked  in  1  destination unavailable (main bus_req, or word RAM not assigned to sub).
- mem_addr  out  19  shared port address.
- mem_dat  out  16  shared port write data.
- mem_oe  out  1  read strobe.
- mem_we  out  1  write strobe.
- owner  out  2  0 = idle, 1 = sub, 2 = dma.

Behaviour:
- Reset:
  - state IDLE; owner = 0.
  - mem_oe = mem_we = 0; mem_addr = 0; mem_dat = 0.
  - dma_ack = 0; sub_wait = 0; wait_ctr = 0.
- States: IDLE, SUB, DMA_WR, DMA_DONE. Transitions are evaluated only on ticks where sub_sync = 1.
- IDLE:
  - If dma_req & !port_blocked & (!sub_req | wait_ctr >= MAX_WAIT): go to DMA_WR. Latch dma_addr/dma_dat onto mem_addr/mem_dat, set mem_we = 1, load hold_ctr = WR_HOLD - 1.
  - Otherwise, if sub_req: go to SUB. Drive mem_addr/mem_dat from sub inputs; mem_oe = !sub_we, mem_we = sub_we.
- SUB:
  - Follows sub_addr/sub_dat combinationally.
  - Stays while sub_req = 1; on sub_req falling, returns to IDLE with strobes cleared on the same tick.
  - A sub cycle is never preempted.
- DMA_WR:
  - sub_wait = 1 whenever sub_req is high during this state.
  - hold_ctr decrements each tick; when hold_ctr = 0, mem_we drops and the state goes to DMA_DONE.
  - If port_blocked rises during DMA_WR, mem_we drops immediately and the state returns to IDLE without an ack. The word is retried later; data stays latched by the requester.
- DMA_DONE:
  - dma_ack = 1 for exactly one tick, then return to IDLE.
  - wait_ctr clears to 0.
  - The requester must drop or advance dma_req the tick after ack. An unchanged dma_req is a new word.
- wait_ctr:
  - Increments (saturating at MAX_WAIT) each tick dma_req = 1 while the state is not DMA_WR/DMA_DONE.
  - Clears when dma_req = 0.
- Simultaneous sub_req and dma_req in IDLE: sub wins unless wait_ctr >= MAX_WAIT.
- port_blocked only gates DMA, never sub.
- Worst-case DMA latency: MAX_WAIT + longest sub cycle + WR_HOLD + 1 ticks.
- Reset mid-transfer: strobes clear on the next clock edge; no ack is emitted.
- Ticks with sub_sync = 0: all registers hold, and outputs keep their current values.

Optional Feature:
- Macro CDC_ARB_STAT_EN.
- When defined, two extra outputs are added:
  - dma_words [15:0]: counts dma_ack pulses.
  - starve_hits [7:0]: counts grants forced by wait_ctr >= MAX_WAIT.
  - Both counters wrap, and both clear on rst.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (mcd_pkg):
  - arb state enum (IDLE, SUB, DMA_WR, DMA_DONE).
  - owner encoding constants (OWN_IDLE = 0, OWN_SUB = 1, OWN_DMA = 2).
  - 19-bit sub address typedef.
- Sub-module: one natural sub-module, cdc_arb_wait_ctr, containing the saturating starvation counter plus force-grant compare. Everything else stays flat.

Test Plan:
- DMA alone: dma_req = 1, addr 0x01000, dat 0xA55A, sub_sync every 4 clocks, WR_HOLD = 2 -> mem_we high for 2 ticks at 0x01000/0xA55A, then one dma_ack tick, owner 2 -> 0.
- Sub priority: sub_req and dma_req rise on the same tick with wait_ctr = 0 -> owner = 1; DMA is granted on the first IDLE tick after sub_req falls.
- Starvation: sub_req back-to-back with 1-tick gaps, dma_req held -> DMA granted no later than the 7th tick (MAX_WAIT = 6); sub_wait is asserted during DMA_WR.
- Blocked abort: port_blocked rises during DMA_WR tick 1 -> mem_we = 0, no dma_ack, IDLE; after port_blocked falls, the same word is rewritten and acked once.
- Reset mid-write: rst during DMA_WR -> mem_we = 0, owner = 0, dma_ack never pulses.
- sub_sync gating: sub_sync = 0 for 10 clocks mid DMA_WR -> state, hold_ctr and mem_we all frozen.
